// File: rtl/cache_pkg.sv
// Shared types and width helpers for the direct-mapped cache controller.
package cache_pkg;

    localparam int unsigned CACHE_ADDR_W = 28;
    localparam int unsigned CACHE_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        RD_MISS,
        WR_THRU,
        RESP
    } state_t;

    function automatic int unsigned idx_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag and data arrays: synchronous write, registered read, no reset on contents.
module cache_line_store #(
    parameter int unsigned LINES  = 16,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned TAG_W  = 24,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              tag_we,
    input  logic              data_we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[wr_idx] <= wr_tag;
        end
        if (data_we) begin
            data_mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_tag  <= tag_mem[rd_idx];
            rd_data <= data_mem[rd_idx];
        end
    end

endmodule

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Optional hit/miss counters are enabled with the CACHE_STATS_EN macro.
module cache_ctrl_dm
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = CACHE_ADDR_W,
    parameter int unsigned DATA_WIDTH = CACHE_DATA_W,
    parameter int unsigned LINES      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    output logic                  cpu_hit,
    input  logic                  flush,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int unsigned IDX_W = idx_w(LINES);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W;

    state_t                state_q, state_d;
    logic                  req_we_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;
    logic                  hit_q, hit_d;
    logic [LINES-1:0]      valid_q;

    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [TAG_W-1:0]      rd_tag;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  hit_c;

    logic                  accept_c, flush_c, fill_c, data_we_c, tag_we_c;
    logic [DATA_WIDTH-1:0] wr_data_c;

    logic [DATA_WIDTH-1:0] cpu_rdata_d;
    logic                  cpu_ready_d, cpu_hit_d;
    logic                  mem_req_d, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;

    assign req_idx = req_addr_q[IDX_W-1:0];
    assign req_tag = req_addr_q[ADDR_WIDTH-1:IDX_W];
    assign hit_c   = valid_q[req_idx] && (rd_tag == req_tag);

    cache_line_store #(
        .LINES  (LINES),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_WIDTH)
    ) u_store (
        .clk     (clk),
        .rd_en   (accept_c),
        .rd_idx  (cpu_addr[IDX_W-1:0]),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .tag_we  (tag_we_c),
        .data_we (data_we_c),
        .wr_idx  (req_idx),
        .wr_tag  (req_tag),
        .wr_data (wr_data_c)
    );

    // Next state, array controls and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        hit_d       = hit_q;
        accept_c    = 1'b0;
        flush_c     = 1'b0;
        fill_c      = 1'b0;
        tag_we_c    = 1'b0;
        data_we_c   = 1'b0;
        wr_data_c   = req_wdata_q;
        cpu_rdata_d = cpu_rdata;
        cpu_ready_d = 1'b0;
        cpu_hit_d   = 1'b0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        case (state_q)
            IDLE: begin
                // A request still shown during its own ready cycle is not a new one.
                if (flush) begin
                    flush_c = 1'b1;
                end else if (cpu_req && !cpu_ready) begin
                    accept_c = 1'b1;
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_d      = hit_c;
                mem_addr_d = req_addr_q;
                if (!req_we_q) begin
                    if (hit_c) begin
                        cpu_ready_d = 1'b1;
                        cpu_hit_d   = 1'b1;
                        cpu_rdata_d = rd_data;
                        state_d     = IDLE;
                    end else begin
                        mem_req_d = 1'b1;
                        state_d   = RD_MISS;
                    end
                end else begin
                    data_we_c   = hit_c;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = req_wdata_q;
                    state_d     = WR_THRU;
                end
            end
            RD_MISS: begin
                if (mem_ack) begin
                    fill_c      = 1'b1;
                    tag_we_c    = 1'b1;
                    data_we_c   = 1'b1;
                    wr_data_c   = mem_rdata;
                    cpu_rdata_d = mem_rdata;
                    cpu_ready_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            WR_THRU: begin
                if (mem_ack) begin
                    cpu_ready_d = 1'b1;
                    cpu_hit_d   = hit_q;
                    state_d     = RESP;
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hit_q       <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            cpu_rdata   <= '0;
            cpu_ready   <= 1'b0;
            cpu_hit     <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            state_q   <= state_d;
            hit_q     <= hit_d;
            cpu_rdata <= cpu_rdata_d;
            cpu_ready <= cpu_ready_d;
            cpu_hit   <= cpu_hit_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if (accept_c) begin
                req_we_q    <= cpu_we;
                req_addr_q  <= cpu_addr;
                req_wdata_q <= cpu_wdata;
            end
        end
    end

    // Valid bits live here so a flush clears every line in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (flush_c) begin
            valid_q <= '0;
        end else if (fill_c) begin
            valid_q[req_idx] <= 1'b1;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (cpu_ready) begin
            if (cpu_hit) begin
                if (hit_count != 32'hFFFF_FFFF) begin
                    hit_count <= hit_count + 32'd1;
                end
            end else if (miss_count != 32'hFFFF_FFFF) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
